// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM of the multicycle RISC-V core.
// Steps each instruction through fetch, decode, execute, memory and write-back,
// using the shared ALU, the unified memory port and the register file.
// Also provides a memory-ready handshake, a sticky illegal-opcode trap and a
// counter of retired instructions.
module multicycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           Op,
  input  logic                 Zero,
  input  logic                 Mem_Ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALU_Op,
  output logic [1:0]           ImmSrc,
  output logic                 Illegal,
  output logic [3:0]           State,
  output logic [CNT_WIDTH-1:0] Instr_Retired
);

  // Opcodes the control unit recognises
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic                   illegal_reg;
  logic [CNT_WIDTH-1:0]   retired_reg;

  // Enables computed from the state alone; reset masks them on the way out
  logic pc_write_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic retire;

  // State register, sticky trap flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_ILLEGAL)
        illegal_reg <= 1'b1;
      if (retire)
        retired_reg <= retired_reg + 1'b1;
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_next    = S_FETCH;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    retire        = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALU_Op        = 2'b00;
    case (state_reg)
      S_FETCH: begin
        // PC+4 goes straight back to the PC while the instruction is latched
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = Mem_Ready;
        pc_write_raw = Mem_Ready;
        state_next   = Mem_Ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BEQ:            state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = Mem_Ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe held until the memory accepts the write
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire        = Mem_Ready;
        state_next    = Mem_Ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALU_Op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALU_Op     = 2'b11;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQ: begin
        // Branch target is already in ALUOut; take it only when rs1 == rs2
        ALUSrcA      = 2'b10;
        ALU_Op       = 2'b01;
        pc_write_raw = Zero;
        retire       = 1'b1;
        state_next   = S_FETCH;
      end
      S_JAL: begin
        // Jump target from ALUOut into PC; ALU forms OldPC+4 for rd
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
        state_next   = S_ALUWB;
      end
      S_ILLEGAL: begin
        state_next = S_ILLEGAL;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    case (Op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // A reset cycle abandons the instruction, so no write may escape it
  assign PCWrite       = pc_write_raw  & ~reset;
  assign MemWrite      = mem_write_raw & ~reset;
  assign IRWrite       = ir_write_raw  & ~reset;
  assign RegWrite      = reg_write_raw & ~reset;
  assign Illegal       = illegal_reg;
  assign State         = state_reg;
  assign Instr_Retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit (4-bit retire counter).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op;
  logic       Zero;
  logic       Mem_Ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, ImmSrc;
  logic [3:0] State;
  logic [3:0] Instr_Retired;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_ret = 4'd0;

  multicycle_control_unit #(.CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op), .ImmSrc(ImmSrc), .Illegal(Illegal),
    .State(State), .Instr_Retired(Instr_Retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sum of all write enables, for "nothing written" checks
  function automatic logic [31:0] enables();
    return {29'd0, 3'(PCWrite) + 3'(MemWrite) + 3'(IRWrite) + 3'(RegWrite)};
  endfunction

  // Run one R-type instruction with memory always ready
  task automatic run_rtype();
    Op = 7'b0110011; Mem_Ready = 1'b1;
    repeat (4) tick();
    exp_ret = exp_ret + 4'd1;
  endtask

  initial begin
    reset = 1'b1; Op = 7'b0110011; Zero = 1'b0; Mem_Ready = 1'b1;
    #1;
    // ---- reset: enables suppressed although FETCH with Mem_Ready=1 ----
    check("rst_irwrite", 32'(IRWrite), 0);
    check("rst_pcwrite", 32'(PCWrite), 0);
    tick();
    check("rst_state", 32'(State), 0);
    check("rst_illegal", 32'(Illegal), 0);
    check("rst_retired", 32'(Instr_Retired), 0);
    tick();
    reset = 1'b0;
    #1;

    // ---- R-type: 0,1,6,8,0 ----
    check("r_fetch_state", 32'(State), 0);
    check("r_fetch_irwrite", 32'(IRWrite), 1);
    check("r_fetch_pcwrite", 32'(PCWrite), 1);
    check("r_fetch_srcb", 32'(ALUSrcB), 2);
    check("r_fetch_res", 32'(ResultSrc), 2);
    tick();
    check("r_dec_state", 32'(State), 1);
    check("r_dec_srca", 32'(ALUSrcA), 1);
    check("r_dec_srcb", 32'(ALUSrcB), 1);
    check("r_dec_regwrite", 32'(RegWrite), 0);
    tick();
    check("r_ex_state", 32'(State), 6);
    check("r_ex_aluop", 32'(ALU_Op), 2);
    check("r_ex_srca", 32'(ALUSrcA), 2);
    check("r_ex_regwrite", 32'(RegWrite), 0);
    tick();
    check("r_wb_state", 32'(State), 8);
    check("r_wb_regwrite", 32'(RegWrite), 1);
    check("r_wb_res", 32'(ResultSrc), 0);
    tick();
    exp_ret = 4'd1;
    check("r_done_state", 32'(State), 0);
    check("r_done_retired", 32'(Instr_Retired), 32'(exp_ret));

    // ---- lw with 3 wait cycles in MEMREAD (8 cycles total) ----
    Op = 7'b0000011;
    tick(); tick();
    check("lw_memadr_state", 32'(State), 2);
    check("lw_memadr_srca", 32'(ALUSrcA), 2);
    tick();
    Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_wait_state", 32'(State), 3);
      check("lw_wait_adrsrc", 32'(AdrSrc), 1);
      tick();
    end
    Mem_Ready = 1'b1;
    #1;
    check("lw_rd_state", 32'(State), 3);
    check("lw_rd_adrsrc", 32'(AdrSrc), 1);
    tick();
    check("lw_wb_state", 32'(State), 4);
    check("lw_wb_res", 32'(ResultSrc), 1);
    check("lw_wb_regwrite", 32'(RegWrite), 1);
    tick();
    exp_ret = exp_ret + 4'd1;
    check("lw_done_state", 32'(State), 0);
    check("lw_done_retired", 32'(Instr_Retired), 32'(exp_ret));

    // ---- sw with 2 wait cycles in MEMWRITE ----
    Op = 7'b0100011;
    #1;
    check("sw_immsrc", 32'(ImmSrc), 1);
    tick(); tick();
    check("sw_memadr_state", 32'(State), 2);
    tick();
    Mem_Ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("sw_wait_state", 32'(State), 5);
      check("sw_wait_memwrite", 32'(MemWrite), 1);
      check("sw_wait_regwrite", 32'(RegWrite), 0);
      tick();
    end
    Mem_Ready = 1'b1;
    #1;
    check("sw_last_memwrite", 32'(MemWrite), 1);
    check("sw_last_regwrite", 32'(RegWrite), 0);
    tick();
    exp_ret = exp_ret + 4'd1;
    check("sw_done_state", 32'(State), 0);
    check("sw_done_memwrite", 32'(MemWrite), 0);
    check("sw_done_retired", 32'(Instr_Retired), 32'(exp_ret));

    // ---- beq taken then not taken (3 cycles each) ----
    Op = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      Zero = 1'(z);
      tick(); tick();
      check("beq_state", 32'(State), 9);
      check("beq_aluop", 32'(ALU_Op), 1);
      check("beq_immsrc", 32'(ImmSrc), 2);
      check("beq_pcwrite", 32'(PCWrite), 32'(z));
      tick();
      exp_ret = exp_ret + 4'd1;
      check("beq_done_state", 32'(State), 0);
      check("beq_done_retired", 32'(Instr_Retired), 32'(exp_ret));
    end
    Zero = 1'b0;

    // ---- jal: 0,1,10,8,0 ----
    Op = 7'b1101111;
    tick(); tick();
    check("jal_state", 32'(State), 10);
    check("jal_pcwrite", 32'(PCWrite), 1);
    check("jal_immsrc", 32'(ImmSrc), 3);
    check("jal_srcb", 32'(ALUSrcB), 2);
    tick();
    check("jal_wb_state", 32'(State), 8);
    check("jal_wb_regwrite", 32'(RegWrite), 1);
    tick();
    exp_ret = exp_ret + 4'd1;
    check("jal_done_retired", 32'(Instr_Retired), 32'(exp_ret));

    // ---- I-type ALU op ----
    Op = 7'b0010011;
    tick(); tick();
    check("i_ex_state", 32'(State), 7);
    check("i_ex_aluop", 32'(ALU_Op), 3);
    check("i_ex_srcb", 32'(ALUSrcB), 1);
    tick(); tick();
    exp_ret = exp_ret + 4'd1;
    check("i_done_state", 32'(State), 0);
    check("i_done_retired", 32'(Instr_Retired), 32'(exp_ret));

    // ---- illegal opcode: trap held for 20 cycles ----
    Op = 7'b0000000;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      check("ill_state", 32'(State), 11);
      check("ill_flag", 32'(Illegal), 1);
      check("ill_enables", enables(), 0);
      tick();
    end
    check("ill_retired", 32'(Instr_Retired), 32'(exp_ret));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    exp_ret = 4'd0;
    check("ill_rst_state", 32'(State), 0);
    check("ill_rst_flag", 32'(Illegal), 0);
    check("ill_rst_retired", 32'(Instr_Retired), 0);

    // ---- reset during MEMWRITE wait ----
    Op = 7'b0100011;
    tick(); tick(); tick();
    Mem_Ready = 1'b0;
    #1;
    check("rmw_state", 32'(State), 5);
    check("rmw_memwrite_pre", 32'(MemWrite), 1);
    reset = 1'b1;
    #1;
    check("rmw_memwrite_rst", 32'(MemWrite), 0);
    tick();
    reset = 1'b0;
    Mem_Ready = 1'b1;
    #1;
    check("rmw_next_state", 32'(State), 0);
    check("rmw_retired", 32'(Instr_Retired), 0);

    // ---- counter wrap at 4 bits ----
    for (int i = 0; i < 15; i++) run_rtype();
    check("wrap_15", 32'(Instr_Retired), 32'(exp_ret));
    check("wrap_15_const", 32'(Instr_Retired), 15);
    run_rtype();
    check("wrap_0", 32'(Instr_Retired), 0);
    check("wrap_state", 32'(State), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
